// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Fetch-side direction/target predictor. A direct-mapped table holds
//   {valid, tag, target, 2-bit counter} per entry. Prediction for fetch_pc is
//   purely combinational. The table is trained at the clock edge from the
//   outcome resolved in execute. The block also flags mispredictions and
//   provides the corrected fetch PC.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   fetch_pc          PC being fetched this cycle
//   pred_taken/target prediction for fetch_pc (target = fetch_pc+4 if not taken)
//   ex_*              resolved instruction from execute, along with the
//                     prediction it carried down the pipe
//   mispredict        redirect/flush request this cycle
//   redirect_pc       correct next PC (meaningful only when mispredict=1)
//   branch_cnt        resolved branches, saturating
//   mispredict_cnt    mispredictions, saturating
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic                  ex_taken,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [CNT_WIDTH-1:0]  branch_cnt,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_W    = DATA_WIDTH - IDX_BITS - 2;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] target;
    logic [1:0]            cnt;
  } entry_t;

  entry_t tbl [ENTRIES];

  // Instructions are word aligned; the low two PC bits never select an entry.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], ex_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Predict (fetch side). The read sees the pre-write table contents, so a
  // same-cycle update to the same index shows up one cycle later.
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] f_idx;
  logic [TAG_W-1:0]    f_tag;
  entry_t              f_ent;
  logic                f_hit;

  assign f_idx = fetch_pc[IDX_BITS+1:2];
  assign f_tag = fetch_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign f_ent = tbl[f_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);

  always_comb begin
    pred_taken  = f_hit && f_ent.cnt[1];
    pred_target = pred_taken ? f_ent.target : fetch_pc + DATA_WIDTH'(4);
  end

  // ---------------------------------------------------------------------------
  // Resolve (execute side)
  // ---------------------------------------------------------------------------
  logic [IDX_BITS-1:0] e_idx;
  logic [TAG_W-1:0]    e_tag;
  entry_t              e_ent;
  logic                e_hit;
  logic                br_resolve;
  logic                br_wrong;

  assign e_idx      = ex_pc[IDX_BITS+1:2];
  assign e_tag      = ex_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign e_ent      = tbl[e_idx];
  assign e_hit      = e_ent.valid && (e_ent.tag == e_tag);
  assign br_resolve = ex_valid && ex_is_branch;

  // A wrong target only matters when the branch was actually taken.
  assign br_wrong = (ex_taken != ex_pred_taken) ||
                    (ex_taken && (ex_target != ex_pred_target));

  always_comb begin
    mispredict  = ex_valid && (ex_is_branch ? br_wrong : ex_pred_taken);
    redirect_pc = (ex_is_branch && ex_taken) ? ex_target
                                             : ex_pc + DATA_WIDTH'(4);
  end

  // ---------------------------------------------------------------------------
  // Table update: at most one entry (the ex_pc index) is written per cycle.
  // A non-branch that was predicted taken came from an aliasing tag hit; that
  // entry is dropped so the same PC stops redirecting fetch.
  // ---------------------------------------------------------------------------
  logic   upd_en;
  entry_t upd_ent;

  always_comb begin
    upd_en  = 1'b0;
    upd_ent = e_ent;
    if (br_resolve) begin
      if (e_hit) begin
        upd_en = 1'b1;
        if (ex_taken) begin
          upd_ent.target = ex_target;
          if (e_ent.cnt != 2'b11) upd_ent.cnt = e_ent.cnt + 2'b01;
        end else begin
          if (e_ent.cnt != 2'b00) upd_ent.cnt = e_ent.cnt - 2'b01;
        end
      end else if (ex_taken) begin
        // Allocate weakly-taken, overwriting whatever aliased here.
        upd_en  = 1'b1;
        upd_ent = '{valid: 1'b1, tag: e_tag, target: ex_target, cnt: 2'b10};
      end
    end else if (ex_valid && ex_pred_taken && e_hit) begin
      upd_en        = 1'b1;
      upd_ent.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: 2'b01};
    end else if (upd_en) begin
      tbl[e_idx] <= upd_ent;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (br_resolve && !(&branch_cnt))
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mispredict && !(&mispredict_cnt))
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int DW  = 32;
  localparam int NE  = 64;
  localparam int CW  = 6;     // small so saturation is reachable
  localparam int MAXC = (1 << CW) - 1;

  logic          clk, rst_n;
  logic [DW-1:0] fetch_pc, pred_target, ex_pc, ex_target, ex_pred_target, redirect_pc;
  logic          pred_taken, ex_valid, ex_is_branch, ex_taken, ex_pred_taken, mispredict;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  branch_predictor #(.DATA_WIDTH(DW), .ENTRIES(NE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain arrays keyed by entry number.
  bit            m_valid [NE];
  longint        m_tag   [NE];
  logic [DW-1:0] m_tgt   [NE];
  int            m_cnt   [NE];
  int            m_bcnt, m_mcnt;

  function automatic int idx_of(input logic [DW-1:0] pc);
    return int'((pc / 4) % NE);
  endfunction
  function automatic longint tag_of(input logic [DW-1:0] pc);
    return longint'(pc) / (4 * NE);
  endfunction
  function automatic bit m_hit(input logic [DW-1:0] pc);
    return m_valid[idx_of(pc)] && m_tag[idx_of(pc)] == tag_of(pc);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endtask

  task automatic m_pred(input logic [DW-1:0] pc, output bit t, output logic [DW-1:0] tg);
    t  = m_hit(pc) && m_cnt[idx_of(pc)] >= 2;
    tg = t ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endtask

  function automatic bit m_misp();
    if (!ex_valid) return 0;
    if (ex_is_branch)
      return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    return ex_pred_taken;
  endfunction

  // One clock: check combinational outputs mid-cycle against the pre-update
  // model, then advance the model with the same edge and check the counters.
  task automatic cycle();
    bit t; logic [DW-1:0] tg; bit mp; int i;
    @(negedge clk);
    m_pred(fetch_pc, t, tg);
    mp = m_misp();
    chk("pred_taken", pred_taken, t);
    chk("pred_target", pred_target, tg);
    chk("mispredict", mispredict, mp);
    if (mp) chk("redirect_pc", redirect_pc,
                (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4);
    @(posedge clk);
    #1;
    i = idx_of(ex_pc);
    if (ex_valid && ex_is_branch) begin
      if (m_hit(ex_pc)) begin
        if (ex_taken) begin
          m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
          m_tgt[i] = ex_target;
        end else m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (ex_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target; m_cnt[i] = 2;
      end
    end else if (ex_valid && ex_pred_taken && m_hit(ex_pc)) begin
      m_valid[i] = 0;
    end
    if (ex_valid && ex_is_branch && m_bcnt < MAXC) m_bcnt++;
    if (mp && m_mcnt < MAXC) m_mcnt++;
    chk("branch_cnt", branch_cnt, m_bcnt);
    chk("mispredict_cnt", mispredict_cnt, m_mcnt);
  endtask

  task automatic set_ex(input bit v, input bit b, input logic [DW-1:0] pc, input bit tk,
                        input logic [DW-1:0] tg, input bit ptk, input logic [DW-1:0] ptg);
    ex_valid = v; ex_is_branch = b; ex_pc = pc; ex_taken = tk;
    ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
  endtask

  function automatic logic [DW-1:0] rnd_pc();
    logic [DW-1:0] tg_hi;
    case ($urandom_range(0, 3))
      0: tg_hi = 32'h0000_0000;
      1: tg_hi = 32'h0000_0100;
      2: tg_hi = 32'h0000_0200;
      default: tg_hi = 32'hFFFF_FF00;
    endcase
    return tg_hi | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic rnd_cycles(input int n);
    bit t; logic [DW-1:0] tg, pc;
    for (int k = 0; k < n; k++) begin
      pc = rnd_pc();
      m_pred(pc, t, tg);
      if ($urandom_range(0, 3) == 0) t = ~t;
      if ($urandom_range(0, 5) == 0) tg = rnd_pc();
      set_ex($urandom_range(0, 4) != 0, $urandom_range(0, 6) != 0, pc,
             $urandom_range(0, 1) == 1, rnd_pc(), t, tg);
      fetch_pc = ($urandom_range(0, 3) == 0) ? pc : rnd_pc();
      cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_pc = 32'h100;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12;
    // 1. Post-reset prediction
    chk("rst_ptk", pred_taken, 0);
    chk("rst_ptg", pred_target, 32'h104);
    chk("rst_misp", mispredict, 0);
    chk("rst_bcnt", branch_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 2. First taken branch allocates
    set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    #1;
    chk("t2_misp", mispredict, 1);
    chk("t2_redir", redirect_pc, 32'h80);
    cycle();
    chk("t2_bcnt", branch_cnt, 1);
    chk("t2_mcnt", mispredict_cnt, 1);
    set_ex(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_ptk", pred_taken, 1);
    chk("t2_ptg", pred_target, 32'h80);
    cycle();

    // 3. Counter walk at 0x100
    repeat (2) begin set_ex(1, 1, 32'h100, 1, 32'h80, 1, 32'h80); cycle(); end
    repeat (2) begin set_ex(1, 1, 32'h100, 0, 32'h80, 1, 32'h80); cycle(); end
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t3_nt01", pred_taken, 0);
    repeat (2) begin set_ex(1, 1, 32'h100, 0, 32'h80, 0, 32'h104); cycle(); end
    set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104); cycle();   // 00 -> 01
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t3_sat00", pred_taken, 0);
    repeat (2) begin set_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104); cycle(); end

    // 4. Alias at index 0
    set_ex(0, 0, 0, 0, 0, 0, 0);
    fetch_pc = 32'h200; #1;
    chk("t4_alias", pred_taken, 0);
    cycle();
    set_ex(1, 0, 32'h100, 0, 0, 1, 32'h80);
    fetch_pc = 32'h100; #1;
    chk("t4_misp", mispredict, 1);
    chk("t4_redir", redirect_pc, 32'h104);
    chk("t4_pre", pred_taken, 1);
    cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t4_inval", pred_taken, 0);

    // 5. Same-cycle fetch and allocation
    set_ex(1, 1, 32'h100, 1, 32'h300, 0, 32'h104); #1;
    chk("t5_same", pred_taken, 0);
    cycle();
    set_ex(0, 0, 0, 0, 0, 0, 0); #1;
    chk("t5_next", pred_taken, 1);
    chk("t5_tgt", pred_target, 32'h300);
    cycle();

    // Wrap of +4 at the top of the address space
    fetch_pc = 32'hFFFF_FFFC; #1;
    chk("wrap", pred_target, 32'h0);
    cycle();

    rnd_cycles(300);

    // 6. Asynchronous reset mid-run
    set_ex(0, 0, 0, 0, 0, 0, 0);
    fetch_pc = 32'h100;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_bcnt", branch_cnt, 0);
    chk("mrst_mcnt", mispredict_cnt, 0);
    chk("mrst_ptk", pred_taken, 0);
    m_reset();
    for (int k = 0; k < 8; k++) begin
      fetch_pc = 32'(k) << 2; #1;
      chk("mrst_all_nt", pred_taken, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Drive mispredict_cnt into saturation
    for (int k = 0; k < MAXC + 5; k++) begin
      set_ex(1, 0, 32'h400, 0, 0, 1, 32'h80);
      cycle();
    end
    chk("sat_mcnt", mispredict_cnt, MAXC);

    rnd_cycles(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
